// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches against their fetch prediction and posts per-thread redirects to fetch.
// One-cycle latency from resolution to redirect; a redirect is held until fetch services its thread unstalled.
module branch_resolve_unit #(
    parameter int ADDRESS_WIDTH = 22,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                       i_Clk,
    input  logic                       i_Reset_n,
    input  logic                       i_Valid,
    input  logic [1:0]                 i_Thread,
    input  logic                       i_Epoch,
    input  logic                       i_Pred_Taken,
    input  logic                       i_Actual_Taken,
    input  logic [ADDRESS_WIDTH-1:0]   i_Branch_PC,
    input  logic [ADDRESS_WIDTH-1:0]   i_Target,
    input  logic                       i_Stall,
    input  logic [1:0]                 i_thread_choice,
    output logic [7:0]                 o_branch_mispredict,
    output logic [4*ADDRESS_WIDTH-1:0] o_mispredict_nottaken,
    output logic [4*ADDRESS_WIDTH-1:0] o_mispredict_pc,
    output logic [3:0]                 o_Epoch,
    output logic [3:0]                 o_Squash,
    output logic [CNT_WIDTH-1:0]       o_Branch_Count,
    output logic [CNT_WIDTH-1:0]       o_Mispredict_Count
);

    logic [3:0]                 r_pend;
    logic [3:0]                 r_dir;
    logic [3:0]                 r_epoch;
    logic [3:0]                 r_squash;
    logic [4*ADDRESS_WIDTH-1:0] r_pc;
    logic [4*ADDRESS_WIDTH-1:0] r_tgt;
    logic [CNT_WIDTH-1:0]       r_bcnt;
    logic [CNT_WIDTH-1:0]       r_mcnt;

    logic       w_accept;
    logic       w_mispredict;
    logic [3:0] w_consume;
    logic [3:0] w_sel;
    logic [7:0] w_bm;

    // A pending thread refuses new resolutions: anything still in flight for it is wrong-path.
    assign w_accept     = i_Valid && (i_Epoch == r_epoch[i_Thread]) && !r_pend[i_Thread];
    assign w_mispredict = w_accept && (i_Pred_Taken != i_Actual_Taken);

    always_comb begin
        w_consume = '0;
        w_sel     = '0;
        w_bm      = '0;
        for (int t = 0; t < 4; t++) begin
            w_consume[t]  = r_pend[t] && !i_Stall && (i_thread_choice == 2'(t));
            w_sel[t]      = w_mispredict && (i_Thread == 2'(t));
            w_bm[2*t+1]   = r_pend[t];
            w_bm[2*t]     = r_dir[t];
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_pend   <= '0;
            r_dir    <= '0;
            r_epoch  <= '0;
            r_squash <= '0;
            r_pc     <= '0;
            r_tgt    <= '0;
            r_bcnt   <= '0;
            r_mcnt   <= '0;
        end else begin
            r_squash <= w_sel;
            if (w_accept)
                r_bcnt <= r_bcnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (w_mispredict)
                r_mcnt <= r_mcnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            for (int t = 0; t < 4; t++) begin
                if (w_sel[t]) begin
                    r_pend[t]                              <= 1'b1;
                    r_dir[t]                               <= i_Pred_Taken;
                    r_pc[t*ADDRESS_WIDTH +: ADDRESS_WIDTH]  <= i_Branch_PC;
                    r_tgt[t*ADDRESS_WIDTH +: ADDRESS_WIDTH] <= i_Target;
                    r_epoch[t]                             <= ~r_epoch[t];
                end else if (w_consume[t]) begin
                    r_pend[t] <= 1'b0;
                end
            end
        end
    end

    assign o_branch_mispredict   = w_bm;
    assign o_mispredict_nottaken = r_tgt;
    assign o_mispredict_pc       = r_pc;
    assign o_Epoch               = r_epoch;
    assign o_Squash              = r_squash;
    assign o_Branch_Count        = r_bcnt;
    assign o_Mispredict_Count    = r_mcnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, counter wrap, async reset, randomized model compare.
module tb_branch_resolve_unit;

    localparam int AW = 22;
    localparam int CW = 16;

    logic          i_Clk = 1'b0;
    logic          i_Reset_n;
    logic          i_Valid;
    logic [1:0]    i_Thread;
    logic          i_Epoch;
    logic          i_Pred_Taken;
    logic          i_Actual_Taken;
    logic [AW-1:0] i_Branch_PC;
    logic [AW-1:0] i_Target;
    logic          i_Stall;
    logic [1:0]    i_thread_choice;
    logic [7:0]    o_branch_mispredict;
    logic [4*AW-1:0] o_mispredict_nottaken;
    logic [4*AW-1:0] o_mispredict_pc;
    logic [3:0]    o_Epoch;
    logic [3:0]    o_Squash;
    logic [CW-1:0] o_Branch_Count;
    logic [CW-1:0] o_Mispredict_Count;

    branch_resolve_unit #(.ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .i_Clk                 (i_Clk),
        .i_Reset_n             (i_Reset_n),
        .i_Valid               (i_Valid),
        .i_Thread              (i_Thread),
        .i_Epoch               (i_Epoch),
        .i_Pred_Taken          (i_Pred_Taken),
        .i_Actual_Taken        (i_Actual_Taken),
        .i_Branch_PC           (i_Branch_PC),
        .i_Target              (i_Target),
        .i_Stall               (i_Stall),
        .i_thread_choice       (i_thread_choice),
        .o_branch_mispredict   (o_branch_mispredict),
        .o_mispredict_nottaken (o_mispredict_nottaken),
        .o_mispredict_pc       (o_mispredict_pc),
        .o_Epoch               (o_Epoch),
        .o_Squash              (o_Squash),
        .o_Branch_Count        (o_Branch_Count),
        .o_Mispredict_Count    (o_Mispredict_Count)
    );

    always #5 i_Clk = ~i_Clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] th, input logic ep, input logic pt,
                         input logic at, input logic [AW-1:0] pc, input logic [AW-1:0] tg,
                         input logic st, input logic [1:0] ch);
        i_Valid = v; i_Thread = th; i_Epoch = ep; i_Pred_Taken = pt; i_Actual_Taken = at;
        i_Branch_PC = pc; i_Target = tg; i_Stall = st; i_thread_choice = ch;
    endtask

    function automatic logic [AW-1:0] pc_slice(input int t);
        return o_mispredict_pc[t*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] tg_slice(input int t);
        return o_mispredict_nottaken[t*AW +: AW];
    endfunction

    // Direction bits only carry meaning while their thread's redirect is pending.
    function automatic logic [7:0] care_mask(input logic [7:0] bm);
        logic [7:0] m;
        m = 8'hAA;
        for (int t = 0; t < 4; t++) if (bm[2*t+1]) m[2*t] = 1'b1;
        return m;
    endfunction

    typedef struct {
        logic          v;
        logic [1:0]    th;
        logic          ep, pt, at;
        logic [AW-1:0] pc, tg;
        logic          st;
        logic [1:0]    ch;
        logic [7:0]    bm;
        logic [3:0]    eo, sq;
        logic [CW-1:0] bc, mc;
        int            sl;
        logic [AW-1:0] xpc, xtg;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [1:0] th, input logic ep, input logic pt,
                                input logic at, input logic [AW-1:0] pc, input logic [AW-1:0] tg,
                                input logic st, input logic [1:0] ch, input logic [7:0] bm,
                                input logic [3:0] eo, input logic [3:0] sq, input int bc, input int mc,
                                input int sl);
        vec_t r;
        r.v = v; r.th = th; r.ep = ep; r.pt = pt; r.at = at; r.pc = pc; r.tg = tg;
        r.st = st; r.ch = ch; r.bm = bm; r.eo = eo; r.sq = sq;
        r.bc = CW'(bc); r.mc = CW'(mc); r.sl = sl; r.xpc = pc; r.xtg = tg;
        return r;
    endfunction

    // Reference model: per-thread arrays updated from the redirect rules.
    bit          m_pend[4];
    bit          m_dir[4];
    bit          m_ep[4];
    int unsigned m_pc[4];
    int unsigned m_tg[4];
    bit [3:0]    m_sq;
    int unsigned m_bc, m_mc;

    function automatic void m_reset();
        for (int t = 0; t < 4; t++) begin
            m_pend[t] = 0; m_dir[t] = 0; m_ep[t] = 0; m_pc[t] = 0; m_tg[t] = 0;
        end
        m_sq = 0; m_bc = 0; m_mc = 0;
    endfunction

    function automatic void m_step();
        bit acc;
        bit cons[4];
        int th;
        th  = int'(i_Thread);
        acc = i_Valid && (i_Epoch == m_ep[th]) && !m_pend[th];
        for (int t = 0; t < 4; t++) cons[t] = m_pend[t] && !i_Stall && (int'(i_thread_choice) == t);
        for (int t = 0; t < 4; t++) if (cons[t]) m_pend[t] = 0;
        m_sq = 0;
        if (acc) begin
            m_bc = (m_bc + 1) % 65536;
            if (i_Pred_Taken != i_Actual_Taken) begin
                m_pend[th] = 1;
                m_dir[th]  = i_Pred_Taken;
                m_pc[th]   = i_Branch_PC;
                m_tg[th]   = i_Target;
                m_ep[th]   = !m_ep[th];
                m_sq[th]   = 1'b1;
                m_mc       = (m_mc + 1) % 65536;
            end
        end
    endfunction

    task automatic m_compare();
        logic [7:0] ebm;
        logic [3:0] eep;
        for (int t = 0; t < 4; t++) begin
            ebm[2*t+1] = m_pend[t];
            ebm[2*t]   = m_dir[t];
            eep[t]     = m_ep[t];
        end
        chk("rnd_mispredict", o_branch_mispredict & care_mask(ebm), ebm & care_mask(ebm));
        chk("rnd_epoch", o_Epoch, eep);
        chk("rnd_squash", o_Squash, m_sq);
        chk("rnd_bcount", o_Branch_Count, m_bc[CW-1:0]);
        chk("rnd_mcount", o_Mispredict_Count, m_mc[CW-1:0]);
        for (int t = 0; t < 4; t++) if (m_pend[t]) begin
            chk("rnd_pc_slice", pc_slice(t), m_pc[t][AW-1:0]);
            chk("rnd_tgt_slice", tg_slice(t), m_tg[t][AW-1:0]);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bm"}, o_branch_mispredict, 0);
        chk({tag, "_nottaken"}, o_mispredict_nottaken, 0);
        chk({tag, "_pc"}, o_mispredict_pc, 0);
        chk({tag, "_epoch"}, o_Epoch, 0);
        chk({tag, "_squash"}, o_Squash, 0);
        chk({tag, "_bcount"}, o_Branch_Count, 0);
        chk({tag, "_mcount"}, o_Mispredict_Count, 0);
    endtask

    vec_t tbl[21];

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 22'h0, 22'h0, 1, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, -1);
        tbl[1]  = mk(1, 2, 0, 0, 1, 22'h000100, 22'h000400, 1, 0, 8'h20, 4'b0100, 4'b0100, 1, 1, 2);
        tbl[2]  = mk(0, 0, 0, 0, 0, 22'h0, 22'h0, 1, 2, 8'h20, 4'b0100, 4'b0000, 1, 1, -1);
        tbl[3]  = tbl[2];
        tbl[4]  = tbl[2];
        tbl[5]  = tbl[2];
        tbl[6]  = tbl[2];
        tbl[7]  = mk(0, 0, 0, 0, 0, 22'h0, 22'h0, 0, 2, 8'h00, 4'b0100, 4'b0000, 1, 1, -1);
        tbl[8]  = mk(1, 1, 0, 1, 1, 22'h000500, 22'h000600, 1, 0, 8'h00, 4'b0100, 4'b0000, 2, 1, -1);
        tbl[9]  = mk(1, 0, 0, 1, 0, 22'h000200, 22'h000300, 1, 1, 8'h03, 4'b0101, 4'b0001, 3, 2, 0);
        tbl[10] = mk(1, 0, 1, 0, 1, 22'h000700, 22'h000800, 0, 0, 8'h00, 4'b0101, 4'b0000, 3, 2, -1);
        tbl[11] = mk(1, 0, 0, 0, 1, 22'h000900, 22'h000A00, 1, 0, 8'h00, 4'b0101, 4'b0000, 3, 2, -1);
        tbl[12] = mk(1, 0, 1, 0, 1, 22'h000240, 22'h000340, 1, 0, 8'h02, 4'b0100, 4'b0001, 4, 3, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 22'h0, 22'h0, 0, 0, 8'h00, 4'b0100, 4'b0000, 4, 3, -1);
        tbl[14] = mk(1, 0, 0, 1, 0, 22'h001000, 22'h002000, 1, 0, 8'h03, 4'b0101, 4'b0001, 5, 4, 0);
        tbl[15] = mk(1, 1, 0, 0, 1, 22'h001100, 22'h002100, 1, 0, 8'h0B, 4'b0111, 4'b0010, 6, 5, 1);
        tbl[16] = mk(1, 3, 0, 1, 0, 22'h001300, 22'h002300, 1, 0, 8'hCB, 4'b1111, 4'b1000, 7, 6, 3);
        tbl[17] = mk(0, 0, 0, 0, 0, 22'h0, 22'h0, 0, 3, 8'h0B, 4'b1111, 4'b0000, 7, 6, -1);
        tbl[18] = mk(1, 2, 1, 0, 1, 22'h001200, 22'h002200, 0, 0, 8'h28, 4'b1011, 4'b0100, 8, 7, 2);
        tbl[19] = mk(0, 0, 0, 0, 0, 22'h0, 22'h0, 0, 1, 8'h20, 4'b1011, 4'b0000, 8, 7, -1);
        tbl[20] = mk(0, 0, 0, 0, 0, 22'h0, 22'h0, 0, 2, 8'h00, 4'b1011, 4'b0000, 8, 7, -1);

        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        i_Reset_n = 1'b0;
        repeat (2) @(posedge i_Clk);
        #1;
        chk_all_zero("reset");
        i_Reset_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].v, tbl[i].th, tbl[i].ep, tbl[i].pt, tbl[i].at, tbl[i].pc, tbl[i].tg,
                  tbl[i].st, tbl[i].ch);
            @(posedge i_Clk);
            #1;
            chk($sformatf("vec%0d_mispredict", i), o_branch_mispredict & care_mask(tbl[i].bm),
                tbl[i].bm & care_mask(tbl[i].bm));
            chk($sformatf("vec%0d_epoch", i), o_Epoch, tbl[i].eo);
            chk($sformatf("vec%0d_squash", i), o_Squash, tbl[i].sq);
            chk($sformatf("vec%0d_bcount", i), o_Branch_Count, tbl[i].bc);
            chk($sformatf("vec%0d_mcount", i), o_Mispredict_Count, tbl[i].mc);
            if (tbl[i].sl >= 0) begin
                chk($sformatf("vec%0d_pc_slice", i), pc_slice(tbl[i].sl), tbl[i].xpc);
                chk($sformatf("vec%0d_tgt_slice", i), tg_slice(tbl[i].sl), tbl[i].xtg);
            end
        end

        // Counter wrap: 65535 correct predictions, then one more.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        i_Reset_n = 1'b0;
        #2;
        i_Reset_n = 1'b1;
        @(posedge i_Clk);
        #1;
        drive(1, 0, 0, 0, 0, 22'h000010, 22'h000020, 1, 0);
        repeat (65535) @(posedge i_Clk);
        #1;
        i_Valid = 1'b0;
        chk("wrap_preload_bcount", o_Branch_Count, 16'hFFFF);
        chk("wrap_preload_mcount", o_Mispredict_Count, 0);
        i_Valid = 1'b1;
        @(posedge i_Clk);
        #1;
        chk("wrap_bcount", o_Branch_Count, 0);

        // Async reset while threads 1 and 3 hold redirects.
        drive(1, 1, 0, 0, 1, 22'h003100, 22'h004100, 1, 0);
        @(posedge i_Clk);
        #1;
        drive(1, 3, 0, 1, 0, 22'h003300, 22'h004300, 1, 0);
        @(posedge i_Clk);
        #1;
        i_Valid = 1'b0;
        chk("prerst_mispredict", o_branch_mispredict & care_mask(8'hC8), 8'hC8);
        chk("prerst_squash", o_Squash, 4'b1000);
        #2;
        i_Reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        #1;
        i_Reset_n = 1'b1;

        m_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] th;
            th = 2'($urandom_range(0, 3));
            drive($urandom_range(0, 9) < 7, th,
                  ($urandom_range(0, 3) == 0) ? !m_ep[th] : m_ep[th],
                  1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
                  $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
            m_step();
            @(posedge i_Clk);
            #1;
            m_compare();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage branch resolution and redirect generator for the 4-thread fetch path. Compares each resolved branch against its fetch-time prediction and, on a mispredict, posts a per-thread redirect (mispredict flag, prediction direction, correct target, branch PC) that the fetch unit holds and consumes. Holds each redirect until fetch selects that thread while not stalled. Keeps a per-thread epoch bit so that wrong-path branches still in flight are discarded.

## Interface
- ADDRESS_WIDTH, 22, PC/target width
- CNT_WIDTH, 16, width of the statistics counters
- i_Clk  in  1  clock
- i_Reset_n  in  1  reset, asynchronous, active-low
- i_Valid  in  1  a branch resolves in EX this cycle
- i_Thread  in  2  thread ID of the resolving branch
- i_Epoch  in  1  epoch tag the branch carried from fetch
- i_Pred_Taken  in  1  fetch-time prediction
- i_Actual_Taken  in  1  resolved direction
- i_Branch_PC  in  ADDRESS_WIDTH  PC of the branch
- i_Target  in  ADDRESS_WIDTH  resolved taken target
- i_Stall  in  1  fetch stall; same signal fetch sees
- i_thread_choice  in  2  thread fetch is servicing this cycle
- o_branch_mispredict  out  8  per thread t: bit[2t+1] = redirect pending, bit[2t] = branch was predicted taken
- o_mispredict_nottaken  out  4*ADDRESS_WIDTH  slice t: correct target for a predicted-not-taken mispredict
- o_mispredict_pc  out  4*ADDRESS_WIDTH  slice t: PC of the mispredicted branch
- o_Epoch  out  4  current epoch per thread; fetch tags new instructions with it
- o_Squash  out  4  one-cycle pulse per thread when a redirect is accepted
- o_Branch_Count  out  CNT_WIDTH  branches accepted (epoch-valid)
- o_Mispredict_Count  out  CNT_WIDTH  mispredicts accepted

## Operation
- A resolution is accepted when all of the following hold:
  - i_Valid = 1
  - i_Epoch == o_Epoch[i_Thread]
  - pend[i_Thread] = 0
- Any other resolution is dropped silently: no state change and no counter increment.
- An accepted resolution always increments o_Branch_Count.
- Mispredict is defined as an accepted resolution with i_Pred_Taken != i_Actual_Taken. On a mispredict for thread t:
  - pend[t] <= 1
  - dir[t] <= i_Pred_Taken
  - pc slice t <= i_Branch_PC
  - nottaken slice t <= i_Target
  - o_Epoch[t] toggles
  - o_Squash[t] pulses for one cycle
  - o_Mispredict_Count increments
- Fetch computes the restart address itself: on dir = 1 it uses the PC slice as fall-through, on dir = 0 it uses the target slice.
- Consume: pend[t] clears when pend[t] = 1, i_Stall = 0 and i_thread_choice == t. The dir, pc and target slices are retained after consume; they are don't-care while pend = 0.
- Pending redirects of different threads are independent. All four threads may be pending at once.
- Counters wrap modulo 2^CNT_WIDTH without saturating.
- Only one resolution arrives per cycle, so at most one thread is written per cycle.

## Timing
- All outputs are registered.
- Reset values: o_branch_mispredict = 0, slices = 0, o_Epoch = 0, o_Squash = 0, both counters = 0.
- Accepted mispredict at edge N → pend, slices, epoch and o_Squash are visible after edge N; o_Squash drops after edge N+1.
- Consume condition sampled at edge M → bit[2t+1] reads 0 after edge M. Fetch therefore sees the redirect for exactly one serviced cycle.
- Same-cycle consume of thread t and a resolution from thread t: that resolution is dropped because pend[t] was still 1.
- Same-cycle consume of thread t and an accepted resolution of thread u ≠ t: both take effect.
- Stall held high: pend holds indefinitely; acceptance for other threads continues.
- Asynchronous reset mid-operation clears all pending redirects and epochs immediately; nothing is replayed.

## Test plan
- Reset, then thread 2, epoch 0, pred = 0, actual = 1, PC = 0x000100, target = 0x000400 → next cycle: o_branch_mispredict = 8'b0010_0000, slice 2 nottaken = 0x000400, o_Epoch = 4'b0100, o_Squash = 4'b0100 for one cycle, counts 1/1.
- Pending on thread 2 with i_Stall = 1 and choice = 2 for 5 cycles → bit5 stays 1. Release stall → bit5 clears after one edge.
- Pending on thread 0, then a thread-0 resolution with epoch 1 in the consume cycle → dropped, counts unchanged. After consume, a thread-0 resolution with stale epoch 0 → dropped.
- Correct prediction: thread 1, pred = 1, actual = 1 → only o_Branch_Count increments. o_branch_mispredict, o_Epoch and o_Squash are unchanged.
- Mispredicts on threads 0, 1, 3 on consecutive cycles → bits 1, 3, 7 set together with their own slices. Consume in order 3, 0, 1 → each clears independently.
- Preload o_Branch_Count to 0xFFFF via 65535 branches, one more → wraps to 0. Assert reset while threads 1 and 3 are pending → all outputs read 0 immediately.
